// File: rtl/mysystem_hps_vga_rdata_fifo_if.sv
// mysystem_hps_vga_rdata_fifo_if: Avalon-MM slave bus between the HPS bridge and the read-back FIFO
//   address    2   word address
//   chipselect 1   slave select
//   read_n     1   read strobe, active low
//   write_n    1   write strobe, active low
//   writedata  32  write data
//   readdata   32  read data, zero wait states, latency 0
interface mysystem_hps_vga_rdata_fifo_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/mysystem_hps_vga_rdata_fifo.sv
// mysystem_hps_vga_rdata_fifo: FPGA-to-HPS read-back FIFO with sticky status and level irq
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   avs        Avalon-MM slave (addr0 pop data, addr1 status, addr2 irq mask, addr3 clear/flush)
//   in_data    word from the FPGA-side producer
//   in_strobe  one-cycle push strobe, no backpressure
//   in_full    FIFO full, advisory to the producer
//   irq        level interrupt: not-empty and/or overflow, per mask
module mysystem_hps_vga_rdata_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int PTR_W      = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    mysystem_hps_vga_rdata_fifo_if.slave    avs,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_strobe,
    output logic                            in_full,
    output logic                            irq
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
    logic [1:0]            mask_q, mask_d;
    logic                  rd, wr, pop, push, flush, ctl_wr;

    always_comb begin
        rd       = avs.chipselect & ~avs.read_n;
        wr       = avs.chipselect & ~avs.write_n;
        ctl_wr   = wr && avs.address == 2'd3;
        flush    = ctl_wr && avs.writedata[2];
        pop      = rd && avs.address == 2'd0 && !empty_q;
        // full is the registered pre-pop value, so a push against a full FIFO drops even if a pop coincides
        push     = in_strobe && !full_q && !flush;
        rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
        count_d  = flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        empty_d  = count_d == '0;
        full_d   = count_d == (PTR_W+1)'(DEPTH);
        // sticky flags: a set in the same cycle as a clear wins
        ovf_d    = (in_strobe && full_q && !flush) || (ovf_q && !(ctl_wr && avs.writedata[0]));
        udf_d    = (rd && avs.address == 2'd0 && empty_q) || (udf_q && !(ctl_wr && avs.writedata[1]));
        mask_d   = (wr && avs.address == 2'd2) ? avs.writedata[1:0] : mask_q;
        // built from next-state values so irq lands in the same cycle as the status it reflects
        irq_d    = (mask_d[0] && !empty_d) || (mask_d[1] && ovf_d);
        avs.readdata = avs.address == 2'd0 ? (empty_q ? '0 : 32'(mem_q[rd_ptr_q])) :
                       avs.address == 2'd1 ? ((32'(count_q) << 16) | {28'b0, udf_q, ovf_q, full_q, empty_q}) :
                       avs.address == 2'd2 ? {30'b0, mask_q} : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_full = full_q;
    assign irq     = irq_q;
endmodule

// File: tb/tb_mysystem_hps_vga_rdata_fifo.sv
// tb_mysystem_hps_vga_rdata_fifo: directed scenario bench for the HPS VGA read-back FIFO
module tb_mysystem_hps_vga_rdata_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_strobe = 1'b0;
    logic        in_full;
    logic        irq;
    int          errors = 0;
    int          checks = 0;

    mysystem_hps_vga_rdata_fifo_if bus();

    mysystem_hps_vga_rdata_fifo dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avs       (bus),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .in_full   (in_full),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // all bus/strobe tasks start and end on a falling edge
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        bus.chipselect = 1'b1;
        bus.read_n = 1'b0;
        #1 d = bus.readdata;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] w);
        in_data = w;
        in_strobe = 1'b1;
        @(negedge clk);
        in_strobe = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=%h", d, 32'h1); end
        checks++;
        if (in_full !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_outputs got=%b%b exp=00", in_full, irq); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL empty_pop_data got=%h exp=0", d); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL underflow_set got=%h exp=%h", d, 32'h9); end
        bus_write(2'd3, 32'h2);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL underflow_clear got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        strobe(16'h1234);
        strobe(16'hABCD);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL basic_count got=%h exp=%h", d, 32'h0002_0000); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h1234) begin errors++; $display("FAIL basic_pop0 got=%h exp=%h", d, 32'h1234); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'hABCD) begin errors++; $display("FAIL basic_pop1 got=%h exp=%h", d, 32'hABCD); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL basic_empty got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        for (int i = 0; i <= 16; i++) strobe(16'(i));
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0010_0006) begin errors++; $display("FAIL full_status got=%h exp=%h", d, 32'h0010_0006); end
        checks++;
        if (in_full !== 1'b1) begin errors++; $display("FAIL in_full got=%b exp=1", in_full); end
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            checks++;
            if (d !== 32'(i)) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, d, 32'(i)); end
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL drained_status got=%h exp=%h", d, 32'h5); end
        bus_write(2'd3, 32'h1);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL overflow_clear got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [31:0] exp_q [3];
        exp_q = '{32'h2, 32'h3, 32'h55};
        strobe(16'h1);
        strobe(16'h2);
        strobe(16'h3);
        in_data = 16'h0055;
        in_strobe = 1'b1;
        bus_read(2'd0, d);
        in_strobe = 1'b0;
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL b2b_head got=%h exp=%h", d, 32'h1); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0003_0000) begin errors++; $display("FAIL b2b_count got=%h exp=%h", d, 32'h0003_0000); end
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd0, d);
            checks++;
            if (d !== exp_q[i]) begin errors++; $display("FAIL b2b_order_%0d got=%h exp=%h", i, d, exp_q[i]); end
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL b2b_empty got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        bus_write(2'd2, 32'hFFFF_FFFD);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL mask_read got=%h exp=%h", d, 32'h1); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq); end
        strobe(16'h7);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_not_empty got=%b exp=1", irq); end
        bus_read(2'd0, d);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
        bus_write(2'd2, 32'h2);
        for (int i = 0; i < 16; i++) strobe(16'(i));
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_full_no_ovf got=%b exp=0", irq); end
        strobe(16'hDEAD);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_overflow got=%b exp=1", irq); end
        bus_write(2'd3, 32'h5);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b exp=0", irq); end
        bus_write(2'd2, 32'h0);
    endtask

    task automatic test_flush_reset;
        logic [31:0] d;
        for (int i = 0; i <= 16; i++) strobe(16'(i));
        bus_write(2'd3, 32'h4);
        for (int i = 0; i < 5; i++) strobe(16'(i + 8'h40));
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0005_0004) begin errors++; $display("FAIL pre_flush got=%h exp=%h", d, 32'h0005_0004); end
        in_data = 16'h0099;
        in_strobe = 1'b1;
        bus_write(2'd3, 32'h4);
        in_strobe = 1'b0;
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL post_flush got=%h exp=%h", d, 32'h5); end
        strobe(16'h0077);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h77) begin errors++; $display("FAIL post_flush_data got=%h exp=%h", d, 32'h77); end
        bus_write(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) strobe(16'(i));
        #2 reset_n = 1'b0;
        bus.address = 2'd1;
        #1;
        checks++;
        if (bus.readdata !== 32'h1) begin errors++; $display("FAIL mid_reset_status got=%h exp=%h", bus.readdata, 32'h1); end
        checks++;
        if (irq !== 1'b0 || in_full !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs got=%b%b exp=00", irq, in_full); end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_mask got=%h exp=0", d); end
    endtask

    initial begin
        bus.address = '0;
        bus.chipselect = 1'b0;
        bus.read_n = 1'b1;
        bus.write_n = 1'b1;
        bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset;
        test_basic;
        test_overflow;
        test_back_to_back;
        test_irq;
        test_flush_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
